// File: rtl/psram_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : psram_rd_arbiter_if
// Purpose  : AXI-style read channel (address handshake + data beats) used
//            for both requester ports and the PSRAM-facing port.
// Revision : 1.0 - initial release
// ============================================================================
interface psram_rd_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 18
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    // Side that issues read bursts
    modport master (
        output araddr,
        output arvalid,
        input  arready,
        input  rdata,
        input  rvalid
    );

    // Side that accepts read bursts and returns data
    modport slave (
        input  araddr,
        input  arvalid,
        output arready,
        output rdata,
        output rvalid
    );
endinterface
`default_nettype wire

// File: rtl/psram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : psram_rd_arbiter
// Purpose  : Two-requester arbiter for the PSRAM read channel. Port 0 is the
//            real-time display fetcher and wins by default; port 1 is granted
//            after STARVE_LIMIT consecutive port-0 wins while it waits. One
//            burst in flight; beats are routed back to the burst owner.
// Revision : 1.0 - initial release
// ============================================================================
module psram_rd_arbiter #(
    parameter int BURST_LEN    = 4,
    parameter int ADDR_W       = 25,
    parameter int DATA_W       = 18,
    parameter int STARVE_LIMIT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               psram_ready,
    psram_rd_arbiter_if.slave  m0,
    psram_rd_arbiter_if.slave  m1,
    psram_rd_arbiter_if.master mem,
    output logic               owner,
    output logic               busy,
    output logic               stray_rvalid
);

    localparam logic [2:0] c_last_beat    = 3'(BURST_LEN - 1);
    localparam logic [2:0] c_burst_len    = 3'(BURST_LEN);
    localparam logic [4:0] c_starve_limit = 5'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_owner;
    logic              r_busy;
    logic              r_stray;
    logic [4:0]        r_starve_cnt;
    logic [2:0]        r_beat_cnt;

    logic              w_grant;
    logic              w_pick1;
    logic              w_addr_hs;
    logic              w_beat;
    logic              w_arvalid;

    // Next-state decode, grant decision and beat qualification
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_addr_hs    = 1'b0;
        w_beat       = 1'b0;
        w_arvalid    = 1'b0;
        // Port 1 wins when alone, or when port 0 has starved it long enough
        w_pick1      = m1.arvalid && (!m0.arvalid || (r_starve_cnt == c_starve_limit));
        case (r_state)
            S_IDLE: begin
                if (psram_ready && !reset && (m0.arvalid || m1.arvalid)) begin
                    w_grant      = 1'b1;
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                w_arvalid = psram_ready;
                if (psram_ready && mem.arready) begin
                    w_addr_hs    = 1'b1;
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                w_beat = psram_ready && mem.rvalid;
                if (w_beat && (r_beat_cnt == c_last_beat)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        // Losing the controller abandons whatever burst was in progress
        if (!psram_ready) begin
            w_next_state = S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the winner's address and identity on the grant edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_araddr <= '0;
            r_owner  <= 1'b0;
        end else if (w_grant) begin
            r_araddr <= w_pick1 ? m1.araddr : m0.araddr;
            r_owner  <= w_pick1;
        end
    end

    // Count port-0 wins while port 1 is waiting; any pause in port 1 clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!psram_ready || !m1.arvalid) begin
            r_starve_cnt <= '0;
        end else if (w_grant) begin
            if (w_pick1) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_starve_limit) begin
                r_starve_cnt <= r_starve_cnt + 5'd1;
            end
        end
    end

    // Beat counter for the burst in flight, held at BURST_LEN once reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_cnt <= '0;
        end else if (w_addr_hs) begin
            r_beat_cnt <= '0;
        end else if (w_beat && (r_beat_cnt != c_burst_len)) begin
            r_beat_cnt <= r_beat_cnt + 3'd1;
        end
    end

    // Registered busy tracks the state we are about to enter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
        end
    end

    // Sticky flag for data beats arriving when no burst expects them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stray <= 1'b0;
        end else if (mem.rvalid && (r_state != S_DATA)) begin
            r_stray <= 1'b1;
        end
    end

    assign m0.arready   = w_grant && !w_pick1;
    assign m1.arready   = w_grant && w_pick1;
    assign mem.araddr   = r_araddr;
    assign mem.arvalid  = w_arvalid;
    assign m0.rvalid    = w_beat && !r_owner;
    assign m1.rvalid    = w_beat && r_owner;
    assign m0.rdata     = mem.rdata;
    assign m1.rdata     = mem.rdata;
    assign owner        = r_owner;
    assign busy         = r_busy;
    assign stray_rvalid = r_stray;

endmodule
`default_nettype wire

// File: doc/psram_rd_arbiter.md
# psram_rd_arbiter

Two-requester arbiter for the PSRAM AXI-style read channel (araddr/arvalid/arready address handshake, rdata/rvalid data beats). It shares one read port between the display-buffer fetcher (port 0, real-time) and a host/dump reader (port 1). Port 1 is protected from starvation. The block sits between both requesters and the PSRAM controller, entirely in the memory clock domain. One burst is in flight at a time, and data beats are routed back to the requester that owns that burst.

## Interface
Parameters:
- BURST_LEN, 4, rvalid beats per read burst (1..7)
- ADDR_W, 25, read address width
- DATA_W, 18, read data width
- STARVE_LIMIT, 16, max consecutive port-0 grants while port 1 waits (1..31)

Ports:
- clk  in  1  memory clock (connect to mem_clk)
- reset  in  1  asynchronous, active-high reset
- psram_ready  in  1  PSRAM controller initialised
- m0_araddr  in  ADDR_W  port 0 burst address
- m0_arvalid  in  1  port 0 request
- m0_arready  out  1  port 0 address accepted
- m0_rdata  out  DATA_W  port 0 read data
- m0_rvalid  out  1  port 0 data beat
- m1_araddr  in  ADDR_W  port 1 burst address
- m1_arvalid  in  1  port 1 request
- m1_arready  out  1  port 1 address accepted
- m1_rdata  out  DATA_W  port 1 read data
- m1_rvalid  out  1  port 1 data beat
- araddr  out  ADDR_W  address to PSRAM
- arvalid  out  1  address valid to PSRAM
- arready  in  1  PSRAM address accept
- rdata  in  DATA_W  PSRAM read data
- rvalid  in  1  PSRAM data beat
- owner  out  1  port owning the current or last burst
- busy  out  1  state is ADDR or DATA
- stray_rvalid  out  1  sticky flag: rvalid seen outside DATA

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - With psram_ready=1 and any mX_arvalid, choose a winner and pulse winner's mX_arready combinationally in the same cycle.
  - Latch winner's address into araddr and set owner. Next state is ADDR.
- Winner selection:
  - Port 0 wins by default.
  - Port 1 wins if only m1_arvalid is high, or if both are high and starve_cnt == STARVE_LIMIT.
- starve_cnt:
  - Increments on each port-0 grant made while m1_arvalid=1.
  - Clears on any port-1 grant, and in any cycle where m1_arvalid=0.
  - Saturates at STARVE_LIMIT.
- ADDR:
  - arvalid=1 with araddr held stable.
  - On arvalid&&arready, go to DATA with beat_cnt=0.
- DATA:
  - Each rvalid increments beat_cnt.
  - mX_rvalid = rvalid when owner==X; the other port sees 0.
  - The beat that brings the count to BURST_LEN returns the block to IDLE on the next edge.
- rdata is broadcast unregistered to both m0_rdata and m1_rdata.
- psram_ready=0 in any state:
  - Next state is IDLE, the burst is abandoned, and starve_cnt is cleared.
  - mX_arready and arvalid are forced to 0 that cycle.
  - mX_rvalid is suppressed from that cycle onward.
- rvalid in IDLE or ADDR:
  - Not forwarded to either port.
  - Sets stray_rvalid, which stays set until reset.
- A requester must hold mX_arvalid and mX_araddr until it sees mX_arready. Dropping mX_arvalid earlier withdraws the request with no side effects.

## Timing
- Reset (asynchronous), applied at any time, including mid-burst:
  - State IDLE; araddr=0, arvalid=0, owner=0, busy=0, stray_rvalid=0, starve_cnt=0, beat_cnt=0.
  - mX_arready=0 and mX_rvalid=0 while reset is asserted.
- Request to PSRAM: mX_arvalid high at edge N (IDLE) → mX_arready high during cycle N → arvalid high from N+1.
- Minimum address phase is 1 cycle, when arready is already high at N+1.
- Beat routing is combinational (zero latency from rvalid to mX_rvalid).
- After the last beat, one IDLE cycle occurs before the next arvalid. Back-to-back bursts therefore use 1 address cycle + BURST_LEN beats + 1 idle cycle.
- busy is registered and equals (state != IDLE).
- owner changes only on a grant edge.
- beat_cnt is 3 bits and does not wrap beyond BURST_LEN.
- starve_cnt is 5 bits.

## Test plan
- Single port-0 request at 0x0000A8 with arready tied 1 and 4 rvalid beats → m0_arready pulses once, araddr=0x0000A8 for 1 cycle, m0_rvalid high 4 cycles, m1_rvalid stays 0, busy returns 0 one cycle after the 4th beat.
- Both ports request continuously, STARVE_LIMIT=16 → grant order is 16× port 0, then 1× port 1, repeating. owner toggles accordingly; no grant goes to port 1 before the 17th burst.
- Port 1 alone requests 3 bursts at 0x100, 0x108, 0x110 with arready delayed 3 cycles → arvalid held 3 cycles per burst with araddr stable, all 12 beats appear on m1_rvalid, m1_rdata matches rdata.
- psram_ready dropped after 2 beats of a port-0 burst → next state is IDLE, remaining beats are not forwarded. After psram_ready returns, a new grant is issued normally.
- rvalid pulsed while IDLE → neither port's rvalid asserts, stray_rvalid=1 and stays 1 until reset.
- Asynchronous reset asserted mid-DATA, between clock edges → all outputs go to their reset values immediately. After release, port-1 request is granted in the first IDLE cycle.
